// File: rtl/pc_stack_pkg.sv
// Shared types and constants for the PC sequencer / return-address stack.
// Optional STACK_GUARD_EN enables overflow/underflow fault detection.
package pc_stack_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_OVF     = 2'b01;
    localparam logic [1:0] FLT_UDF     = 2'b10;
    localparam logic [1:0] FLT_PUSHPOP = 2'b11;

    // Stack pointer needs one extra bit so a full stack (sp == SDEPTH) is representable.
    function automatic int calc_spw(input int sdepth);
        return $clog2(sdepth) + 1;
    endfunction

endpackage

// File: rtl/pc_stack_ctrl_ret_stack.sv
// Return-address storage: SDEPTH x MINSTW registers, synchronous write,
// asynchronous read so a RETURN can load the PC in the same cycle.
module ret_stack #(
    parameter int MINSTW = 8,
    parameter int SDEPTH = 16,
    parameter int IW     = $clog2(SDEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [MINSTW-1:0] wdata,
    input  logic [IW-1:0]     raddr,
    output logic [MINSTW-1:0] rdata
);

    logic [MINSTW-1:0] r_mem [SDEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/pc_stack_ctrl.sv
// PC sequencer with return-address stack: increment, jump, CALL, RETURN.
// Define STACK_GUARD_EN to trap stack overflow/underflow and push&pop into FAULT.
module pc_stack_ctrl
    import pc_stack_pkg::*;
#(
    parameter  int MINSTW = 8,
    parameter  int SDEPTH = 16,
    localparam int SPW    = calc_spw(SDEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MINSTW-1:0] instr_addr,
    input  logic              pc_load,
    input  logic              isp_push,
    input  logic              isp_pop,
    output logic [MINSTW-1:0] addr,
    output logic [SPW-1:0]    sp,
    output logic              running,
    output logic              fault,
    output logic [1:0]        fault_code
);

    localparam int IW = SPW - 1;
`ifdef STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    state_t            r_state, w_state_next;
    logic [MINSTW-1:0] r_addr, w_addr_next;
    logic [SPW-1:0]    r_sp, w_sp_next;
    logic [1:0]        r_fault_code, w_fault_code_next;
    logic              w_we;
    logic [IW-1:0]     w_waddr, w_raddr;
    logic [MINSTW-1:0] w_wdata, w_rdata;
    logic [MINSTW-1:0] w_addr_inc;

    assign w_addr_inc = r_addr + MINSTW'(1);
    assign w_waddr    = r_sp[IW-1:0];
    assign w_raddr    = r_sp[IW-1:0] - IW'(1);
    assign w_wdata    = w_addr_inc;

    ret_stack #(
        .MINSTW (MINSTW),
        .SDEPTH (SDEPTH),
        .IW     (IW)
    ) u_ret_stack (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (w_raddr),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_BOOT;
            r_addr       <= '0;
            r_sp         <= '0;
            r_fault_code <= FLT_NONE;
        end else begin
            r_state      <= w_state_next;
            r_addr       <= w_addr_next;
            r_sp         <= w_sp_next;
            r_fault_code <= w_fault_code_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_addr_next       = r_addr;
        w_sp_next         = r_sp;
        w_fault_code_next = r_fault_code;
        w_we              = 1'b0;

        if (en) begin
            case (r_state)
                ST_BOOT: w_state_next = ST_RUN;
                ST_RUN: begin
                    if (isp_push && isp_pop) begin
                        if (GUARD) begin
                            w_state_next      = ST_FAULT;
                            w_fault_code_next = FLT_PUSHPOP;
                        end else begin
                            w_addr_next = w_addr_inc;
                        end
                    end else if (isp_pop) begin
                        if (GUARD && r_sp == '0) begin
                            w_state_next      = ST_FAULT;
                            w_fault_code_next = FLT_UDF;
                        end else begin
                            w_addr_next = w_rdata;
                            w_sp_next   = r_sp - SPW'(1);
                        end
                    end else if (isp_push) begin
                        if (GUARD && r_sp == SPW'(SDEPTH)) begin
                            w_state_next      = ST_FAULT;
                            w_fault_code_next = FLT_OVF;
                        end else begin
                            w_we        = 1'b1;
                            w_sp_next   = r_sp + SPW'(1);
                            w_addr_next = pc_load ? instr_addr : w_addr_inc;
                        end
                    end else if (pc_load) begin
                        w_addr_next = instr_addr;
                    end else begin
                        w_addr_next = w_addr_inc;
                    end
                end
                default: ;
            endcase
        end

        // Unguarded stack is circular: pointer wraps modulo SDEPTH.
        if (!GUARD) begin
            w_sp_next[SPW-1] = 1'b0;
        end
    end

    assign addr       = r_addr;
    assign sp         = r_sp;
    assign running    = (r_state == ST_RUN);
    assign fault      = GUARD && (r_state == ST_FAULT);
    assign fault_code = GUARD ? r_fault_code : FLT_NONE;

endmodule

// File: tb/tb_pc_stack_ctrl.sv
// Directed self-checking bench for pc_stack_ctrl (MINSTW=8, SDEPTH=16).
// Guard-specific vectors are selected by STACK_GUARD_EN.
module tb_pc_stack_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] instr_addr;
    logic       pc_load;
    logic       isp_push;
    logic       isp_pop;
    logic [7:0] addr;
    logic [4:0] sp;
    logic       running;
    logic       fault;
    logic [1:0] fault_code;

    int n_checks;
    int n_errors;

    pc_stack_ctrl #(
        .MINSTW (8),
        .SDEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .instr_addr (instr_addr),
        .pc_load    (pc_load),
        .isp_push   (isp_push),
        .isp_pop    (isp_pop),
        .addr       (addr),
        .sp         (sp),
        .running    (running),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic push, input logic pop, input logic load, input logic [7:0] ia);
        isp_push   = push;
        isp_pop    = pop;
        pc_load    = load;
        instr_addr = ia;
    endtask

    // Reset, release, and run through BOOT so the core is in RUN at addr 0.
    task automatic reset_and_boot();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        en       = 1'b0;
        rst      = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        @(negedge clk);

        check("reset_addr", 32'(addr), 32'h00);
        check("reset_sp", 32'(sp), 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_fault", 32'(fault), 32'h0);
        check("reset_code", 32'(fault_code), 32'h0);

        rst = 1'b1;
        en  = 1'b1;
        step();
        check("boot_running", 32'(running), 32'h1);
        check("boot_addr", 32'(addr), 32'h00);
        step();
        check("first_inc", 32'(addr), 32'h01);

        // Jumps
        drive(1'b0, 1'b0, 1'b1, 8'h10); step();
        check("jmp_10", 32'(addr), 32'h10);
        drive(1'b0, 1'b0, 1'b1, 8'h40); step();
        check("jmp_40", 32'(addr), 32'h40);
        check("jmp_sp", 32'(sp), 32'h0);

        // Wrap 0xFE -> 0xFF -> 0x00
        drive(1'b0, 1'b0, 1'b1, 8'hFE); step();
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        check("wrap_ff", 32'(addr), 32'hFF);
        step();
        check("wrap_00", 32'(addr), 32'h00);

        // CALL 0x80 from 0x05, then RETURN
        drive(1'b0, 1'b0, 1'b1, 8'h05); step();
        drive(1'b1, 1'b0, 1'b1, 8'h80); step();
        check("call_addr", 32'(addr), 32'h80);
        check("call_sp", 32'(sp), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        check("callee_inc", 32'(addr), 32'h81);
        drive(1'b0, 1'b1, 1'b0, 8'hAA); step();
        check("ret_addr", 32'(addr), 32'h06);
        check("ret_sp", 32'(sp), 32'h0);

        // Nested CALLs from 0x10
        drive(1'b0, 1'b0, 1'b1, 8'h10); step();
        drive(1'b1, 1'b0, 1'b1, 8'h20); step();
        drive(1'b1, 1'b0, 1'b1, 8'h30); step();
        drive(1'b1, 1'b0, 1'b1, 8'h40); step();
        check("nest_addr", 32'(addr), 32'h40);
        check("nest_sp", 32'(sp), 32'h3);
        drive(1'b0, 1'b1, 1'b0, 8'h00); step();
        check("nret1_addr", 32'(addr), 32'h31);
        check("nret1_sp", 32'(sp), 32'h2);
        step();
        check("nret2_addr", 32'(addr), 32'h21);
        check("nret2_sp", 32'(sp), 32'h1);
        step();
        check("nret3_addr", 32'(addr), 32'h11);
        check("nret3_sp", 32'(sp), 32'h0);

        // Stall with pc_load pending
        en = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 8'h55); step(); step();
        check("stall_addr", 32'(addr), 32'h11);
        check("stall_sp", 32'(sp), 32'h0);
        en = 1'b1; step();
        check("resume_addr", 32'(addr), 32'h55);

        // Asynchronous reset mid-CALL
        drive(1'b1, 1'b0, 1'b1, 8'h90); step();
        check("pre_rst_sp", 32'(sp), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_addr", 32'(addr), 32'h00);
        check("async_rst_sp", 32'(sp), 32'h0);
        check("async_rst_running", 32'(running), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rst_boot_running", 32'(running), 32'h1);
        check("rst_boot_addr", 32'(addr), 32'h00);

`ifdef STACK_GUARD_EN
        // Underflow
        drive(1'b0, 1'b1, 1'b0, 8'h00); step();
        check("udf_fault", 32'(fault), 32'h1);
        check("udf_code", 32'(fault_code), 32'h2);
        check("udf_addr", 32'(addr), 32'h00);
        check("udf_running", 32'(running), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 8'h00); step();
        check("udf_frozen", 32'(addr), 32'h00);

        // Overflow on the 17th push
        reset_and_boot();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h60 + i)); step();
        end
        check("full_sp", 32'(sp), 32'h10);
        check("full_fault", 32'(fault), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 8'h70); step();
        check("ovf_fault", 32'(fault), 32'h1);
        check("ovf_code", 32'(fault_code), 32'h1);
        check("ovf_sp", 32'(sp), 32'h10);
        check("ovf_addr", 32'(addr), 32'h6F);
        drive(1'b1, 1'b1, 1'b0, 8'h00); step();
        check("ovf_code_sticky", 32'(fault_code), 32'h1);

        // Simultaneous push and pop
        reset_and_boot();
        drive(1'b1, 1'b1, 1'b1, 8'h33); step();
        check("pp_code", 32'(fault_code), 32'h3);
        check("pp_sp", 32'(sp), 32'h0);
`else
        // Circular stack: 17 pushes wrap and overwrite the oldest entry
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(8'h60 + i)); step();
        end
        check("wrap16_sp", 32'(sp), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 8'h70); step();
        check("wrap17_sp", 32'(sp), 32'h1);
        check("wrap17_fault", 32'(fault), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 8'h00); step();
        check("wrap_pop_addr", 32'(addr), 32'h70);
        check("wrap_pop_sp", 32'(sp), 32'h0);
        step();
        check("udf_pop_addr", 32'(addr), 32'h6F);
        check("udf_pop_sp", 32'(sp), 32'hF);
        check("udf_fault", 32'(fault), 32'h0);
        check("udf_code", 32'(fault_code), 32'h0);
        check("udf_running", 32'(running), 32'h1);

        // Push and pop together: stack untouched, PC increments
        drive(1'b1, 1'b1, 1'b1, 8'h33); step();
        check("pp_addr", 32'(addr), 32'h70);
        check("pp_sp", 32'(sp), 32'hF);
        check("pp_fault", 32'(fault), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
